// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: state encodings and link defaults shared by both ends of the serial link
package tdm_demux_pkg;
    typedef logic [0:0] state_t;
    localparam state_t HUNT   = 1'b0;
    localparam state_t LOCKED = 1'b1;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_SW       = 2;
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial slot input and reassembled parallel output of the demux
interface tdm_demux_if #(parameter int CHANNELS = 4, parameter int SW = 2);
    logic                d;
    logic                sync;
    logic                en;
    logic [CHANNELS-1:0] q;
    logic                valid;
    logic [SW-1:0]       sel;
    logic                err;
    logic                locked;
    modport master (output d, sync, en, input q, valid, sel, err, locked);
    modport slave  (input d, sync, en, output q, valid, sel, err, locked);
endinterface

// File: rtl/tdm_demux_slot_counter.sv
// slot_counter: slot index counter with clear, load-to-1 and wrap at CHANNELS-1
module slot_counter #(
    parameter int CHANNELS = 4,
    parameter int SW       = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          load1,
    input  logic          clr,
    output logic [SW-1:0] cnt
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load1)
            cnt <= SW'(1);
        else if (en)
            cnt <= (cnt == SW'(CHANNELS - 1)) ? '0 : cnt + SW'(1);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: locks onto the frame marker and reassembles slot bits into a CHANNELS-bit word
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SW       = DEF_SW
) (
    input  logic        clk,
    input  logic        reset,
    tdm_demux_if.slave  bus
);
    state_t              state;
    logic [CHANNELS-1:0] shadow;
    logic [CHANNELS-1:0] q_r;
    logic                valid_r;
    logic                err_r;
    logic [SW-1:0]       k;
    logic                hit;
    logic                first;
    logic                last;
    logic                miss;
    logic                early;
    logic                done;
    logic                load1;
    logic                inc;
    assign hit   = bus.en && state == LOCKED;
    assign first = k == '0;
    assign last  = k == SW'(CHANNELS - 1);
    assign miss  = hit && first && !bus.sync;
    assign early = hit && !first && bus.sync;
    assign done  = hit && last && !bus.sync;
    assign load1 = bus.en && bus.sync;
    assign inc   = hit && !first && !bus.sync;
    slot_counter #(.CHANNELS(CHANNELS), .SW(SW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (inc),
        .load1 (load1),
        .clr   (miss),
        .cnt   (k)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= HUNT;
            shadow  <= '0;
            q_r     <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            valid_r <= done;
            err_r   <= miss || early;
            // a marker always restarts the frame, dropping any partial one
            if (load1) begin
                state  <= LOCKED;
                shadow <= CHANNELS'(bus.d);
            end else if (miss) begin
                state  <= HUNT;
                shadow <= '0;
            end else if (inc)
                shadow[k] <= bus.d;
            if (done)
                q_r <= {bus.d, shadow[CHANNELS-2:0]};
        end
    assign bus.q      = q_r;
    assign bus.valid  = valid_r;
    assign bus.err    = err_r;
    assign bus.sel    = k;
    assign bus.locked = state == LOCKED;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed frames with hand-computed words, strobes and lock state
module tb_tdm_demux;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t_valid = 0;
    tdm_demux_if #(.CHANNELS(4), .SW(2)) bus ();
    tdm_demux #(.CHANNELS(4), .SW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input logic dd, input logic ss, input logic ee);
        bus.d    = dd;
        bus.sync = ss;
        bus.en   = ee;
        @(posedge clk);
        #1;
    endtask
    task automatic check_all(input string tag, input logic [3:0] q, input logic v,
                             input logic e, input logic [1:0] s, input logic l);
        check({tag, ".q"}, bus.q, q);
        check({tag, ".valid"}, bus.valid, v);
        check({tag, ".err"}, bus.err, e);
        check({tag, ".sel"}, bus.sel, s);
        check({tag, ".locked"}, bus.locked, l);
    endtask
    initial begin
        bus.d = 1'b0;
        bus.sync = 1'b0;
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_all("reset", 4'h0, 0, 0, 2'd0, 0);
        // clean frame 1,0,1,1
        step(1, 1, 1); check_all("f1s0", 4'h0, 0, 0, 2'd1, 1);
        step(0, 0, 1); check("f1s1.sel", bus.sel, 2);
        step(1, 0, 1); check("f1s2.sel", bus.sel, 3);
        step(1, 0, 1); check_all("f1done", 4'b1101, 1, 0, 2'd0, 1);
        step(0, 0, 0); check_all("f1idle", 4'b1101, 0, 0, 2'd0, 1);
        // back-to-back frames 0,1,1,0 then 1,1,1,1
        step(0, 1, 1); step(1, 0, 1); step(1, 0, 1);
        step(0, 0, 1); check_all("f2done", 4'b0110, 1, 0, 2'd0, 1);
        t_valid = cyc;
        step(1, 1, 1); check("f3s0.valid", bus.valid, 0);
        step(1, 0, 1); check("f3s1.valid", bus.valid, 0);
        step(1, 0, 1); check("f3s2.valid", bus.valid, 0);
        step(1, 0, 1); check_all("f3done", 4'b1111, 1, 0, 2'd0, 1);
        check("f3spacing", cyc - t_valid, 4);
        // missing marker at slot 0, then relock
        step(1, 0, 1); check_all("miss", 4'b1111, 0, 1, 2'd0, 0);
        step(0, 0, 1); check_all("hunt", 4'b1111, 0, 0, 2'd0, 0);
        step(1, 1, 1); check_all("relock", 4'b1111, 0, 0, 2'd1, 1);
        // early marker at slot 2 starts frame 0,0,1,0
        step(0, 0, 1); check("pre.sel", bus.sel, 2);
        step(0, 1, 1); check_all("early", 4'b1111, 0, 1, 2'd1, 1);
        step(0, 0, 1); check("e1.err", bus.err, 0);
        step(1, 0, 1);
        step(0, 0, 1); check_all("edone", 4'b0100, 1, 0, 2'd0, 1);
        // en toggling, frame 1,1,0,1
        step(1, 1, 1); check("t0.sel", bus.sel, 1);
        step(0, 0, 0); check_all("t0hold", 4'b0100, 0, 0, 2'd1, 1);
        step(1, 0, 1); check("t1.sel", bus.sel, 2);
        step(0, 0, 0); check("t1hold.sel", bus.sel, 2);
        step(0, 0, 1); check("t2.sel", bus.sel, 3);
        step(1, 1, 0); check_all("t2hold", 4'b0100, 0, 0, 2'd3, 1);
        step(1, 0, 1); check_all("tdone", 4'b1011, 1, 0, 2'd0, 1);
        // asynchronous reset mid-frame
        step(1, 1, 1); step(0, 0, 1);
        check("mid.sel", bus.sel, 2);
        #2 reset = 1'b1;
        #1 check_all("async", 4'h0, 0, 0, 2'd0, 0);
        step(1, 1, 1); check_all("rstpulse", 4'h0, 0, 0, 2'd0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1);
            check_all("nolock", 4'h0, 0, 0, 2'd0, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the team's mux-based serial link. The transmit side drives one bit per slot, with its select walking through CHANNELS inputs. This block locks onto the frame marker, routes each incoming slot bit to its channel position, and presents the reassembled CHANNELS-bit word with a one-cycle valid strobe. It sits between the serial line and the parallel consumer logic.

## Interface
- CHANNELS, 4, slots per frame (≥2); one data bit per slot
- SW, 2, select/counter width; must satisfy 2**SW ≥ CHANNELS
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  asynchronous, active-high reset
- d  input  1  serial slot data
- sync  input  1  frame marker; high together with the slot-0 bit
- en  input  1  slot strobe; d/sync sampled only on edges with en=1
- q  output  CHANNELS  last complete frame; q[i] = bit of slot i
- valid  output  1  one-cycle pulse when q is updated
- sel  output  SW  index of the slot expected on the next en edge
- err  output  1  one-cycle pulse on a framing error
- locked  output  1  high while the state is LOCKED

## Operation
- States are HUNT (reset state) and LOCKED.
- Edges with en=0: no state, counter or data change; valid=0 and err=0 on the following cycle.
- HUNT:
  - An en edge with sync=1 stores d into shadow[0], sets sel=1 and moves to LOCKED.
  - An en edge with sync=0 is discarded; sel stays 0 and there is no err.
- LOCKED, on an en edge, with slot index k=sel:
  - If k=0 and sync=1: store d into shadow[0]; sel=1.
  - If k=0 and sync=0: missing marker. Pulse err, go to HUNT, set sel=0, discard the shadow.
  - If 0<k and sync=1: early marker. Pulse err, treat this bit as slot 0 (shadow[0]=d, sel=1), stay LOCKED, and drop the partial frame; q is not updated.
  - If 0<k<CHANNELS-1 and sync=0: shadow[k]=d; sel=k+1.
  - If k=CHANNELS-1 and sync=0: q = {d, shadow[CHANNELS-2:0]}; pulse valid; sel wraps to 0.
- q holds its value between frames. Only a complete, error-free frame updates q.
- err and valid are never asserted together.
- Reset, including mid-frame, forces: state HUNT, sel=0, shadow=0, q=0, valid=0, err=0, locked=0.

## Timing
- All outputs are registered and change only on the rising clk edge or on reset.
- Latency: q and valid change on the same edge that samples the last slot. valid is high for exactly that one following cycle.
- Back-to-back frames with en held high give valid once every CHANNELS cycles, with no dead cycle between frames.
- locked rises on the edge that accepts the first sync in HUNT. It falls on the edge that detects a missing marker.
- Reset release: the first edge with reset=0 may sample. An en/sync pulse coincident with reset is ignored.

## Structure
- A shared constants file holds the state encodings (HUNT=1'b0, LOCKED=1'b1) and the CHANNELS/SW defaults. The transmit mux side uses the same file, so slot numbering matches on both ends.
- One sub-module, slot_counter: an SW-bit counter with enable, synchronous load-to-1 and clear, wrapping at CHANNELS-1 → 0, with async reset. The top level holds the FSM, the shadow register, q and the strobes.
- q is updated from a single register path. Do not use a combinational bypass from d to q.

## Test plan
All scenarios use CHANNELS=4 and en=1 unless stated otherwise.
- Reset, then clean frame with sync on slot 0 and slot bits 1,0,1,1 → q=4'b1101, valid for 1 cycle after the 4th edge, locked=1, err=0.
- Two back-to-back frames 0,1,1,0 then 1,1,1,1 → q=4'b0110 then 4'b1111, with valid pulses exactly 4 cycles apart.
- Locked, sync missing at slot 0 → err pulse, locked=0, sel=0, q retains the previous frame. The next sync relocks.
- Early sync at slot 2 of a frame → err pulse, no valid, q unchanged. The new frame 0,0,1,0 starting at that bit → q=4'b0100.
- en toggled 1,0,1,0… within a frame of bits 1,1,0,1 → q=4'b1011 after 4 enabled edges; sel holds during en=0 cycles.
- Reset asserted asynchronously mid-frame (sel=2) → all outputs 0 immediately, without waiting for a clock edge. After release, sync=0 traffic gives no err and no lock.
